// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - reorder buffer with multi-port writeback, dual-slot commit and mispredict flush
module rob_multi #(
    parameter int DEPTH_LOG = 4,
    parameter int NUM_WB    = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_W     = 5,
    parameter int TAG_W     = DEPTH_LOG + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    output logic                     rob_next_full,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_pc,
    input  logic [REG_W-1:0]         issue_rd,
    input  logic [2:0]               issue_kind,
    input  logic                     issue_pred_jump,
    input  logic                     issue_ready,
    output logic [TAG_W-1:0]         issue_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_val,
    input  logic [NUM_WB-1:0]        wb_jump,
    input  logic [NUM_WB*ADDR_W-1:0] wb_target,
    input  logic [2*TAG_W-1:0]       q_tag,
    output logic [1:0]               q_ready,
    output logic [2*DATA_W-1:0]      q_val,
    output logic [1:0]               reg_we,
    output logic [2*REG_W-1:0]       reg_rd,
    output logic [2*DATA_W-1:0]      reg_val,
    output logic [1:0]               commit_cnt,
    output logic [TAG_W-1:0]         commit_tag,
    output logic                     st_commit,
    output logic [TAG_W-1:0]         st_tag,
    output logic [TAG_W-1:0]         head_tag,
    output logic                     br_commit,
    output logic                     br_real_jump,
    output logic [ADDR_W-1:0]        br_pc,
    output logic                     clr,
    output logic                     set_pc,
    output logic [ADDR_W-1:0]        target_pc
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;
    localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BR = 3'd3, K_JALR = 3'd4;

    logic              ent_ready [DEPTH];
    logic [REG_W-1:0]  rd_q      [DEPTH];
    logic [DATA_W-1:0] val_q     [DEPTH];
    logic [ADDR_W-1:0] pc_q      [DEPTH];
    logic [2:0]        kind_q    [DEPTH];
    logic              pred_q    [DEPTH];
    logic              real_q    [DEPTH];
    logic [ADDR_W-1:0] target_q  [DEPTH];

    logic [DEPTH_LOG-1:0] head, tail, head1;
    logic [DEPTH_LOG-1:0] sidx [2];
    logic [CW-1:0]        count, count_nxt;
    logic                 c0, c1, issue_fire, st_go, br_go, br_jump_n, mis;
    logic [1:0]           slot_go, ccnt, reg_we_n;
    logic [2*REG_W-1:0]   reg_rd_n;
    logic [2*DATA_W-1:0]  reg_val_n;
    logic [TAG_W-1:0]     st_tag_n;
    logic [ADDR_W-1:0]    br_pc_n, tgt_n;
    logic [TAG_W-1:0]     qt [2];

    assign head1     = head + DEPTH_LOG'(1);
    assign issue_tag = {1'b1, tail};
    assign head_tag  = {1'b1, head};

    // Slot 1 only rides along behind an ALU/LOAD head, so at most one store,
    // branch or mispredict can appear per cycle.
    always_comb begin
        sidx[0]   = head;
        sidx[1]   = head1;
        c0        = !clr && (count != '0) && ent_ready[head];
        c1        = c0 && (kind_q[head] == K_ALU || kind_q[head] == K_LOAD)
                    && (count >= CW'(2)) && ent_ready[head1];
        slot_go   = {c1, c0};
        ccnt      = {1'b0, c0} + {1'b0, c1};
        reg_we_n  = '0;
        reg_rd_n  = '0;
        reg_val_n = '0;
        st_go     = 1'b0;
        st_tag_n  = '0;
        br_go     = 1'b0;
        br_jump_n = 1'b0;
        br_pc_n   = '0;
        mis       = 1'b0;
        tgt_n     = '0;
        for (int s = 0; s < 2; s++) begin
            if (slot_go[s]) begin
                if (kind_q[sidx[s]] == K_ALU || kind_q[sidx[s]] == K_LOAD || kind_q[sidx[s]] == K_JALR) begin
                    reg_we_n[s]                    = 1'b1;
                    reg_rd_n[s*REG_W +: REG_W]     = rd_q[sidx[s]];
                    reg_val_n[s*DATA_W +: DATA_W]  = val_q[sidx[s]];
                end
                if (kind_q[sidx[s]] == K_STORE) begin
                    st_go    = 1'b1;
                    st_tag_n = {1'b1, sidx[s]};
                end
                if (kind_q[sidx[s]] == K_BR) begin
                    br_go     = 1'b1;
                    br_jump_n = real_q[sidx[s]];
                    br_pc_n   = pc_q[sidx[s]];
                end
                if ((kind_q[sidx[s]] == K_BR || kind_q[sidx[s]] == K_JALR)
                    && (pred_q[sidx[s]] != real_q[sidx[s]])) begin
                    mis   = 1'b1;
                    tgt_n = target_q[sidx[s]];
                end
            end
        end
        issue_fire = rdy && issue_valid && !clr;
        if (!rdy)
            count_nxt = count;
        else if (clr)
            count_nxt = '0;
        else
            count_nxt = count + CW'(issue_fire) - CW'(ccnt);
        rob_next_full = !clr && (count_nxt == CW'(DEPTH));
    end

    // Operand query: a same-cycle writeback beats the stored entry; untagged operands are ready.
    always_comb begin
        q_ready = '0;
        q_val   = '0;
        for (int q = 0; q < 2; q++) begin
            qt[q]      = q_tag[q*TAG_W +: TAG_W];
            q_ready[q] = ent_ready[qt[q][DEPTH_LOG-1:0]];
            q_val[q*DATA_W +: DATA_W] = val_q[qt[q][DEPTH_LOG-1:0]];
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == qt[q]) begin
                    q_ready[q] = 1'b1;
                    q_val[q*DATA_W +: DATA_W] = wb_val[p*DATA_W +: DATA_W];
                end
            end
            if (!qt[q][TAG_W-1]) begin
                q_ready[q] = 1'b1;
                q_val[q*DATA_W +: DATA_W] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_ready[i] <= 1'b0;
                rd_q[i]      <= '0;
                val_q[i]     <= '0;
                pc_q[i]      <= '0;
                kind_q[i]    <= '0;
                pred_q[i]    <= 1'b0;
                real_q[i]    <= 1'b0;
                target_q[i]  <= '0;
            end
            reg_we <= '0;
            reg_rd <= '0;
            reg_val <= '0;
            commit_cnt <= '0;
            commit_tag <= '0;
            st_commit <= 1'b0;
            st_tag <= '0;
            br_commit <= 1'b0;
            br_real_jump <= 1'b0;
            br_pc <= '0;
            clr <= 1'b0;
            set_pc <= 1'b0;
            target_pc <= '0;
        end else if (rdy) begin
            reg_we       <= reg_we_n;
            reg_rd       <= reg_rd_n;
            reg_val      <= reg_val_n;
            commit_cnt   <= ccnt;
            commit_tag   <= c0 ? {1'b1, head} : '0;
            st_commit    <= st_go;
            st_tag       <= st_tag_n;
            br_commit    <= br_go;
            br_real_jump <= br_jump_n;
            br_pc        <= br_pc_n;
            clr          <= mis;
            set_pc       <= mis;
            if (mis)
                target_pc <= tgt_n;
            count <= count_nxt;
            if (clr) begin
                head <= '0;
                tail <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_ready[i] <= 1'b0;
                    rd_q[i]      <= '0;
                    val_q[i]     <= '0;
                    pc_q[i]      <= '0;
                    kind_q[i]    <= '0;
                    pred_q[i]    <= 1'b0;
                    real_q[i]    <= 1'b0;
                    target_q[i]  <= '0;
                end
            end else begin
                head <= head + DEPTH_LOG'(ccnt);
                if (issue_valid) begin
                    ent_ready[tail] <= issue_ready;
                    rd_q[tail]      <= issue_rd;
                    pc_q[tail]      <= issue_pc;
                    kind_q[tail]    <= issue_kind;
                    pred_q[tail]    <= issue_pred_jump;
                    real_q[tail]    <= 1'b0;
                    tail            <= tail + DEPTH_LOG'(1);
                end
                // Later ports overwrite earlier ones, and all override the issue write.
                for (int p = 0; p < NUM_WB; p++) begin
                    if (wb_valid[p]) begin
                        ent_ready[wb_tag[p*TAG_W +: DEPTH_LOG]] <= 1'b1;
                        val_q[wb_tag[p*TAG_W +: DEPTH_LOG]]     <= wb_val[p*DATA_W +: DATA_W];
                        real_q[wb_tag[p*TAG_W +: DEPTH_LOG]]    <= wb_jump[p];
                        target_q[wb_tag[p*TAG_W +: DEPTH_LOG]]  <= wb_target[p*ADDR_W +: ADDR_W];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - directed bench for rob_multi
module tb_rob_multi;
    logic        clk, rst_n, rdy;
    logic        rob_next_full;
    logic        issue_valid;
    logic [31:0] issue_pc;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_kind;
    logic        issue_pred_jump, issue_ready;
    logic [4:0]  issue_tag;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_tag;
    logic [63:0] wb_val;
    logic [1:0]  wb_jump;
    logic [63:0] wb_target;
    logic [9:0]  q_tag;
    logic [1:0]  q_ready;
    logic [63:0] q_val;
    logic [1:0]  reg_we;
    logic [9:0]  reg_rd;
    logic [63:0] reg_val;
    logic [1:0]  commit_cnt;
    logic [4:0]  commit_tag;
    logic        st_commit;
    logic [4:0]  st_tag;
    logic [4:0]  head_tag;
    logic        br_commit, br_real_jump;
    logic [31:0] br_pc;
    logic        clr, set_pc;
    logic [31:0] target_pc;

    int tests = 0;
    int fails = 0;

    rob_multi dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rob_next_full(rob_next_full),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_rd(issue_rd),
        .issue_kind(issue_kind), .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready),
        .issue_tag(issue_tag), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .wb_jump(wb_jump), .wb_target(wb_target), .q_tag(q_tag), .q_ready(q_ready),
        .q_val(q_val), .reg_we(reg_we), .reg_rd(reg_rd), .reg_val(reg_val),
        .commit_cnt(commit_cnt), .commit_tag(commit_tag), .st_commit(st_commit),
        .st_tag(st_tag), .head_tag(head_tag), .br_commit(br_commit),
        .br_real_jump(br_real_jump), .br_pc(br_pc), .clr(clr), .set_pc(set_pc),
        .target_pc(target_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        issue_valid = 0; issue_pc = '0; issue_rd = '0; issue_kind = '0;
        issue_pred_jump = 0; issue_ready = 0;
        wb_valid = '0; wb_tag = '0; wb_val = '0; wb_jump = '0; wb_target = '0;
        q_tag = '0;
    endtask

    task automatic do_reset;
        rst_n = 0; rdy = 1;
        idle_inputs();
        step(); step();
        rst_n = 1;
    endtask

    task automatic set_issue(input logic [2:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pred, input logic rdy_in);
        issue_valid = 1; issue_kind = kind; issue_rd = rd; issue_pc = pc;
        issue_pred_jump = pred; issue_ready = rdy_in;
    endtask

    task automatic test_reset;
        rst_n = 0; rdy = 1;
        idle_inputs();
        #2;
        tests++; if (commit_cnt !== 2'd0) begin fails++; $display("FAIL reset_commit_cnt got %0h exp 0", commit_cnt); end
        tests++; if ({clr, set_pc, st_commit, br_commit} !== 4'b0) begin fails++; $display("FAIL reset_pulses got %b exp 0000", {clr, set_pc, st_commit, br_commit}); end
        tests++; if (target_pc !== 32'h0) begin fails++; $display("FAIL reset_target_pc got %0h exp 0", target_pc); end
        tests++; if (issue_tag !== 5'h10 || head_tag !== 5'h10) begin fails++; $display("FAIL reset_tags got %0h/%0h exp 10/10", issue_tag, head_tag); end
        step(); rst_n = 1;
        // commit one entry, then reset asynchronously while the pulse is showing
        set_issue(3'd0, 5'd2, 32'h0, 1'b0, 1'b1);
        step(); idle_inputs();
        step();
        tests++; if (commit_cnt !== 2'd1) begin fails++; $display("FAIL pre_async_commit got %0h exp 1", commit_cnt); end
        #2; rst_n = 0; #1;
        tests++; if (commit_cnt !== 2'd0 || reg_we !== 2'b00 || head_tag !== 5'h10) begin
            fails++; $display("FAIL async_reset got cnt %0h we %b head %0h exp 0 00 10", commit_cnt, reg_we, head_tag); end
        step(); rst_n = 1;
    endtask

    task automatic test_fill;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(3'd0, 5'(i), 32'(i * 4), 1'b0, 1'b0);
            #1;
            tests++; if (issue_tag !== 5'(16 + i)) begin fails++; $display("FAIL fill_tag_%0d got %0h exp %0h", i, issue_tag, 16 + i); end
            tests++; if (rob_next_full !== (i == 15)) begin fails++; $display("FAIL fill_full_%0d got %b exp %b", i, rob_next_full, i == 15); end
            step();
        end
        idle_inputs(); #1;
        tests++; if (rob_next_full !== 1'b1) begin fails++; $display("FAIL fill_full_hold got %b exp 1", rob_next_full); end
        tests++; if (commit_cnt !== 2'd0) begin fails++; $display("FAIL fill_no_commit got %0h exp 0", commit_cnt); end
    endtask

    task automatic test_dual_commit;
        do_reset();
        set_issue(3'd0, 5'd3, 32'h100, 1'b0, 1'b0); step();
        set_issue(3'd0, 5'd4, 32'h104, 1'b0, 1'b0); step();
        idle_inputs();
        wb_valid = 2'b11; wb_tag = {5'h11, 5'h10}; wb_val = {32'hB, 32'hA};
        step();
        idle_inputs();
        tests++; if (commit_cnt !== 2'd0) begin fails++; $display("FAIL dual_early got %0h exp 0", commit_cnt); end
        step();
        tests++; if (commit_cnt !== 2'd2) begin fails++; $display("FAIL dual_cnt got %0h exp 2", commit_cnt); end
        tests++; if (reg_we !== 2'b11) begin fails++; $display("FAIL dual_we got %b exp 11", reg_we); end
        tests++; if (reg_rd !== {5'd4, 5'd3}) begin fails++; $display("FAIL dual_rd got %0h exp %0h", reg_rd, {5'd4, 5'd3}); end
        tests++; if (reg_val !== {32'hB, 32'hA}) begin fails++; $display("FAIL dual_val got %0h exp b0000000a", reg_val); end
        tests++; if (commit_tag !== 5'h10 || head_tag !== 5'h12) begin fails++; $display("FAIL dual_tags got %0h/%0h exp 10/12", commit_tag, head_tag); end
        step();
        tests++; if (commit_cnt !== 2'd0 || reg_we !== 2'b00) begin fails++; $display("FAIL dual_pulse got %0h/%b exp 0/00", commit_cnt, reg_we); end
    endtask

    task automatic test_store_block;
        do_reset();
        set_issue(3'd2, 5'd0, 32'h200, 1'b0, 1'b0); step();
        set_issue(3'd0, 5'd5, 32'h204, 1'b0, 1'b0); step();
        idle_inputs();
        wb_valid = 2'b11; wb_tag = {5'h11, 5'h10}; wb_val = {32'h77, 32'h55};
        step();
        idle_inputs();
        step();
        tests++; if (commit_cnt !== 2'd1 || st_commit !== 1'b1) begin fails++; $display("FAIL store_commit got cnt %0h st %b exp 1 1", commit_cnt, st_commit); end
        tests++; if (st_tag !== 5'h10 || reg_we !== 2'b00) begin fails++; $display("FAIL store_tag got %0h we %b exp 10 00", st_tag, reg_we); end
        step();
        tests++; if (commit_cnt !== 2'd1 || reg_we !== 2'b01 || st_commit !== 1'b0) begin
            fails++; $display("FAIL store_next got cnt %0h we %b st %b exp 1 01 0", commit_cnt, reg_we, st_commit); end
        tests++; if (reg_rd[4:0] !== 5'd5 || reg_val[31:0] !== 32'h77 || commit_tag !== 5'h11) begin
            fails++; $display("FAIL store_alu got rd %0d val %0h tag %0h exp 5 77 11", reg_rd[4:0], reg_val[31:0], commit_tag); end
    endtask

    task automatic test_mispredict;
        do_reset();
        set_issue(3'd3, 5'd0, 32'h200, 1'b0, 1'b0); step();
        for (int i = 1; i <= 3; i++) begin
            set_issue(3'd0, 5'(i), 32'(32'h200 + 4 * i), 1'b0, 1'b1); step();
        end
        idle_inputs();
        tests++; if (commit_cnt !== 2'd0) begin fails++; $display("FAIL mis_head_block got %0h exp 0", commit_cnt); end
        wb_valid = 2'b01; wb_tag = {5'h0, 5'h10}; wb_jump = 2'b01; wb_target = {32'h0, 32'h1000};
        step();
        idle_inputs();
        step();
        tests++; if (clr !== 1'b1 || set_pc !== 1'b1 || target_pc !== 32'h1000) begin
            fails++; $display("FAIL mis_flush got clr %b set %b tgt %0h exp 1 1 1000", clr, set_pc, target_pc); end
        tests++; if (br_commit !== 1'b1 || br_real_jump !== 1'b1 || br_pc !== 32'h200 || commit_cnt !== 2'd1) begin
            fails++; $display("FAIL mis_br got br %b jump %b pc %0h cnt %0h exp 1 1 200 1", br_commit, br_real_jump, br_pc, commit_cnt); end
        set_issue(3'd0, 5'd9, 32'h300, 1'b0, 1'b1);
        #1;
        tests++; if (rob_next_full !== 1'b0) begin fails++; $display("FAIL mis_full got %b exp 0", rob_next_full); end
        step();
        tests++; if (clr !== 1'b0 || set_pc !== 1'b0 || target_pc !== 32'h1000) begin
            fails++; $display("FAIL mis_after got clr %b set %b tgt %0h exp 0 0 1000", clr, set_pc, target_pc); end
        tests++; if (issue_tag !== 5'h10 || head_tag !== 5'h10 || commit_cnt !== 2'd0) begin
            fails++; $display("FAIL mis_empty got itag %0h htag %0h cnt %0h exp 10 10 0", issue_tag, head_tag, commit_cnt); end
        issue_rd = 5'd7;
        step();
        idle_inputs();
        tests++; if (commit_cnt !== 2'd0) begin fails++; $display("FAIL mis_younger_gone got %0h exp 0", commit_cnt); end
        step();
        tests++; if (commit_cnt !== 2'd1 || commit_tag !== 5'h10 || reg_rd[4:0] !== 5'd7) begin
            fails++; $display("FAIL mis_reissue got cnt %0h tag %0h rd %0d exp 1 10 7", commit_cnt, commit_tag, reg_rd[4:0]); end
    endtask

    task automatic test_query;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_issue(3'd1, 5'(i), 32'h0, 1'b0, 1'b0); step();
        end
        idle_inputs();
        q_tag = {5'h05, 5'h14};
        #1;
        tests++; if (q_ready !== 2'b10 || q_val !== 64'h0) begin fails++; $display("FAIL query_idle got %b %0h exp 10 0", q_ready, q_val); end
        q_tag = {5'h14, 5'h15};
        wb_valid = 2'b01; wb_tag = {5'h0, 5'h15}; wb_val = {32'h0, 32'h1234};
        #1;
        tests++; if (q_ready !== 2'b01 || q_val[31:0] !== 32'h1234) begin fails++; $display("FAIL query_fwd got %b %0h exp 01 1234", q_ready, q_val[31:0]); end
        wb_valid = 2'b11; wb_tag = {5'h15, 5'h15}; wb_val = {32'h2222, 32'h1111};
        #1;
        tests++; if (q_val[31:0] !== 32'h2222) begin fails++; $display("FAIL query_prio got %0h exp 2222", q_val[31:0]); end
        step();
        wb_valid = '0;
        #1;
        tests++; if (q_ready !== 2'b01 || q_val[31:0] !== 32'h2222) begin fails++; $display("FAIL query_stored got %b %0h exp 01 2222", q_ready, q_val[31:0]); end
    endtask

    task automatic test_back_to_back;
        int issued, committed, cyc;
        logic fire, was_rdy;
        logic [1:0] prev_cnt;
        logic [4:0] exp_tag;
        do_reset();
        issued = 0; committed = 0; cyc = 0; prev_cnt = 2'd0;
        while (committed < 40 && cyc < 600) begin
            rdy = ((cyc / 3) % 2) == 0;
            issue_valid = (issued < 40) && (issued - committed < 16);
            issue_kind = 3'd0; issue_ready = 1'b1; issue_rd = 5'(issued % 32);
            fire = rdy && issue_valid;
            was_rdy = rdy;
            step();
            if (fire) issued++;
            if (was_rdy) begin
                for (int s = 0; s < 2; s++) begin
                    if (s < int'(commit_cnt)) begin
                        exp_tag = 5'h10 | 5'(committed % 16);
                        tests++; if (reg_we[s] !== 1'b1 || reg_rd[s*5 +: 5] !== 5'(committed % 32)) begin
                            fails++; $display("FAIL wrap_order_%0d got we %b rd %0d exp 1 %0d", committed, reg_we[s], reg_rd[s*5 +: 5], committed % 32); end
                        if (s == 0) begin
                            tests++; if (commit_tag !== exp_tag) begin fails++; $display("FAIL wrap_tag_%0d got %0h exp %0h", committed, commit_tag, exp_tag); end
                        end
                        committed++;
                    end
                end
            end else begin
                tests++; if (commit_cnt !== prev_cnt) begin fails++; $display("FAIL wrap_hold got %0h exp %0h", commit_cnt, prev_cnt); end
            end
            prev_cnt = commit_cnt;
            cyc++;
        end
        idle_inputs(); rdy = 1;
        tests++; if (committed !== 40 || issued !== 40) begin fails++; $display("FAIL wrap_total got %0d/%0d exp 40/40", committed, issued); end
        step(); step();
        tests++; if (commit_cnt !== 2'd0 || head_tag !== 5'h18) begin fails++; $display("FAIL wrap_drain got cnt %0h head %0h exp 0 18", commit_cnt, head_tag); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_dual_commit();
        test_store_block();
        test_mispredict();
        test_query();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
